// File: rtl/alu_arbiter_if.sv
// Request/response and ALU-side signal bundle for alu_arbiter; master is the
// requester/ALU environment, slave is the arbiter.
interface alu_arbiter_if;
   logic        req0_valid, req1_valid;
   logic        req0_ready, req1_ready;
   logic [3:0]  req0_cmd, req1_cmd;
   logic [31:0] req0_a, req1_a, req0_b, req1_b;
   logic        req0_s, req1_s;
   logic        rsp0_valid, rsp1_valid;
   logic        rsp0_ready, rsp1_ready;
   logic [31:0] rsp_result;
   logic [3:0]  rsp_status;
   logic [31:0] alu_a, alu_b;
   logic [3:0]  alu_cmd;
   logic        alu_carry_in;
   logic [31:0] alu_result;
   logic [3:0]  alu_status;
   logic [3:0]  status_reg;

   modport master (
      output req0_valid, req1_valid, req0_cmd, req1_cmd, req0_a, req1_a,
             req0_b, req1_b, req0_s, req1_s, rsp0_ready, rsp1_ready,
             alu_result, alu_status,
      input  req0_ready, req1_ready, rsp0_valid, rsp1_valid, rsp_result,
             rsp_status, alu_a, alu_b, alu_cmd, alu_carry_in, status_reg
   );

   modport slave (
      input  req0_valid, req1_valid, req0_cmd, req1_cmd, req0_a, req1_a,
             req0_b, req1_b, req0_s, req1_s, rsp0_ready, rsp1_ready,
             alu_result, alu_status,
      output req0_ready, req1_ready, rsp0_valid, rsp1_valid, rsp_result,
             rsp_status, alu_a, alu_b, alu_cmd, alu_carry_in, status_reg
   );
endinterface

// File: rtl/alu_arbiter.sv
// Two-port arbiter for one shared ALU with NZCV status register; response 2 cycles after accept.
// rspN_ready low holds RESP indefinitely and no new request is readied until the response is taken.
module alu_arbiter #(
   parameter bit ROUND_ROBIN = 1'b1
) (
   input logic         clk,
   input logic         rst,
   alu_arbiter_if.slave bus
);
   typedef enum logic [1:0] {IDLE = 2'd0, EXEC = 2'd1, RESP = 2'd2} state_t;

   state_t      state;
   logic        owner;
   logic        lastGrant;
   logic [3:0]  opCmd;
   logic [31:0] opA;
   logic [31:0] opB;
   logic        opS;
   logic [31:0] rspResult;
   logic [3:0]  rspStatus;
   logic [3:0]  statusReg;
   logic        rsp0Vld;
   logic        rsp1Vld;
   logic        grant0;
   logic        grant1;
   logic        accept0;
   logic        accept1;
   logic        rspTaken;

   // On a tie, round-robin favours the port not granted last time.
   always_comb begin
      grant0 = 1'b0;
      grant1 = 1'b0;
      if (bus.req0_valid && bus.req1_valid) begin
         if (ROUND_ROBIN && !lastGrant) grant1 = 1'b1;
         else                           grant0 = 1'b1;
      end else begin
         grant0 = bus.req0_valid;
         grant1 = bus.req1_valid;
      end
   end

   assign bus.req0_ready = (state == IDLE) && grant0 && !rst;
   assign bus.req1_ready = (state == IDLE) && grant1 && !rst;
   assign accept0        = bus.req0_valid && bus.req0_ready;
   assign accept1        = bus.req1_valid && bus.req1_ready;
   assign rspTaken       = (rsp0Vld && bus.rsp0_ready) || (rsp1Vld && bus.rsp1_ready);

   always_ff @(posedge clk or posedge rst) begin
      if (rst) begin
         state     <= IDLE;
         owner     <= 1'b0;
         lastGrant <= 1'b1;
         opCmd     <= 4'd0;
         opA       <= 32'd0;
         opB       <= 32'd0;
         opS       <= 1'b0;
         rspResult <= 32'd0;
         rspStatus <= 4'd0;
         statusReg <= 4'd0;
         rsp0Vld   <= 1'b0;
         rsp1Vld   <= 1'b0;
      end else begin
         case (state)
            IDLE: begin
               if (accept0 || accept1) begin
                  owner     <= accept1;
                  lastGrant <= accept1;
                  opCmd     <= accept1 ? bus.req1_cmd : bus.req0_cmd;
                  opA       <= accept1 ? bus.req1_a   : bus.req0_a;
                  opB       <= accept1 ? bus.req1_b   : bus.req0_b;
                  opS       <= accept1 ? bus.req1_s   : bus.req0_s;
                  state     <= EXEC;
               end
            end
            EXEC: begin
               rspResult <= bus.alu_result;
               rspStatus <= bus.alu_status;
               if (opS) statusReg <= bus.alu_status;
               rsp0Vld   <= !owner;
               rsp1Vld   <= owner;
               state     <= RESP;
            end
            RESP: begin
               if (rspTaken) begin
                  rsp0Vld <= 1'b0;
                  rsp1Vld <= 1'b0;
                  state   <= IDLE;
               end
            end
            default: state <= IDLE;
         endcase
      end
   end

   assign bus.alu_cmd      = opCmd;
   assign bus.alu_a        = opA;
   assign bus.alu_b        = opB;
   assign bus.alu_carry_in = statusReg[1];
   assign bus.rsp0_valid   = rsp0Vld;
   assign bus.rsp1_valid   = rsp1Vld;
   assign bus.rsp_result   = rspResult;
   assign bus.rsp_status   = rspStatus;
   assign bus.status_reg   = statusReg;
endmodule

// File: tb/tb_alu_arbiter.sv
// Scoreboard bench for alu_arbiter: a round-robin and a fixed-priority instance,
// each with a behavioural ALU, driven by directed vectors with hand-computed results.
module tb_alu_arbiter;
    localparam logic [3:0] MOV = 4'b0001, MVN = 4'b1001, ADD = 4'b0010, ADC = 4'b0011;
    localparam logic [3:0] SUB = 4'b0100, SBC = 4'b0101, AND = 4'b0110, ORR = 4'b0111, EOR = 4'b1000;

    typedef struct packed {
        logic        port;
        logic [31:0] res;
        logic [3:0]  st;
        logic [3:0]  sreg;
    } exp_t;

    logic clk = 1'b0;
    logic rst;
    int   cyc = 0;
    int   checks = 0;
    int   errors = 0;
    exp_t qA[$];
    exp_t qB[$];
    int   accCyc[2];
    logic prevV[2];

    always #5 clk = ~clk;
    always @(posedge clk) cyc++;

    alu_arbiter_if busA();
    alu_arbiter_if busB();

    alu_arbiter #(.ROUND_ROBIN(1'b1)) dutA (.clk(clk), .rst(rst), .bus(busA));
    alu_arbiter #(.ROUND_ROBIN(1'b0)) dutB (.clk(clk), .rst(rst), .bus(busB));

    // Behavioural ALU: {N,Z,C,V,result}; SUB/SBC carry means no borrow, logic ops pass C through.
    function automatic logic [35:0] aluModel(input logic [3:0] c, input logic [31:0] a,
                                             input logic [31:0] b, input logic cin);
        logic [32:0] w;
        logic [31:0] r;
        logic        cf;
        logic        vf;
        cf = cin;
        vf = 1'b0;
        w  = 33'd0;
        case (c)
            MOV: r = b;
            MVN: r = ~b;
            ADD, ADC: begin
                w  = {1'b0, a} + {1'b0, b} + {32'd0, (c == ADC) ? cin : 1'b0};
                r  = w[31:0];
                cf = w[32];
                vf = (a[31] == b[31]) && (r[31] != a[31]);
            end
            SUB, SBC: begin
                w  = {1'b0, a} + {1'b0, ~b} + {32'd0, (c == SUB) ? 1'b1 : cin};
                r  = w[31:0];
                cf = w[32];
                vf = (a[31] != b[31]) && (r[31] != a[31]);
            end
            AND: r = a & b;
            ORR: r = a | b;
            EOR: r = a ^ b;
            default: r = 32'd0;
        endcase
        return {r[31], (r == 32'd0), cf, vf, r};
    endfunction

    always_comb {busA.alu_status, busA.alu_result} = aluModel(busA.alu_cmd, busA.alu_a, busA.alu_b, busA.alu_carry_in);
    always_comb {busB.alu_status, busB.alu_result} = aluModel(busB.alu_cmd, busB.alu_a, busB.alu_b, busB.alu_carry_in);

    task automatic chk(input string name, input logic [31:0] act, input logic [31:0] exp);
        checks++;
        if (act !== exp) begin
            errors++;
            $display("FAIL %s got %h want %h (cycle %0d)", name, act, exp, cyc);
        end
    endtask

    task automatic pushExp(input int d, input logic p, input logic [31:0] r,
                           input logic [3:0] st, input logic [3:0] sreg);
        exp_t e;
        e = '{port: p, res: r, st: st, sreg: sreg};
        if (d == 0) qA.push_back(e);
        else        qB.push_back(e);
    endtask

    // Pops the expected response whenever a response handshake is seen.
    task automatic monitor(input int d, input logic v0, input logic v1, input logic rd0,
                           input logic rd1, input logic acc, input logic [31:0] res,
                           input logic [3:0] st, input logic [3:0] sreg);
        exp_t e;
        logic v;
        int   qs;
        v = v0 | v1;
        if (acc) accCyc[d] = cyc;
        if (v && !prevV[d]) chk($sformatf("latency_dut%0d", d), cyc, accCyc[d] + 2);
        prevV[d] = v;
        if ((v0 && rd0) || (v1 && rd1)) begin
            qs = (d == 0) ? qA.size() : qB.size();
            if (qs == 0) begin
                checks++;
                errors++;
                $display("FAIL unexpected_rsp dut%0d got result %h with no response pending", d, res);
            end else begin
                e = (d == 0) ? qA.pop_front() : qB.pop_front();
                chk($sformatf("rsp_port_dut%0d", d), {30'd0, v1, v0}, {30'd0, e.port, !e.port});
                chk($sformatf("rsp_result_dut%0d", d), res, e.res);
                chk($sformatf("rsp_status_dut%0d", d), {28'd0, st}, {28'd0, e.st});
                chk($sformatf("status_reg_dut%0d", d), {28'd0, sreg}, {28'd0, e.sreg});
            end
        end
    endtask

    always @(negedge clk) begin
        if (rst) begin
            prevV[0] = 1'b0;
            prevV[1] = 1'b0;
        end else begin
            monitor(0, busA.rsp0_valid, busA.rsp1_valid, busA.rsp0_ready, busA.rsp1_ready,
                    (busA.req0_valid && busA.req0_ready) || (busA.req1_valid && busA.req1_ready),
                    busA.rsp_result, busA.rsp_status, busA.status_reg);
            monitor(1, busB.rsp0_valid, busB.rsp1_valid, busB.rsp0_ready, busB.rsp1_ready,
                    (busB.req0_valid && busB.req0_ready) || (busB.req1_valid && busB.req1_ready),
                    busB.rsp_result, busB.rsp_status, busB.status_reg);
        end
    end

    task automatic setReq(input int d, input int p, input logic v, input logic [3:0] c,
                          input logic [31:0] a, input logic [31:0] b, input logic s);
        if (d == 0 && p == 0) begin
            busA.req0_valid = v; busA.req0_cmd = c; busA.req0_a = a; busA.req0_b = b; busA.req0_s = s;
        end else if (d == 0) begin
            busA.req1_valid = v; busA.req1_cmd = c; busA.req1_a = a; busA.req1_b = b; busA.req1_s = s;
        end else if (p == 0) begin
            busB.req0_valid = v; busB.req0_cmd = c; busB.req0_a = a; busB.req0_b = b; busB.req0_s = s;
        end else begin
            busB.req1_valid = v; busB.req1_cmd = c; busB.req1_a = a; busB.req1_b = b; busB.req1_s = s;
        end
    endtask

    function automatic logic getRdy(input int d, input int p);
        if (d == 0) return (p == 0) ? busA.req0_ready : busA.req1_ready;
        return (p == 0) ? busB.req0_ready : busB.req1_ready;
    endfunction

    // Holds the request until accepted, then drops valid just after the accepting edge.
    task automatic sendReq(input int d, input int p, input logic [3:0] c,
                           input logic [31:0] a, input logic [31:0] b, input logic s);
        int n;
        n = 0;
        setReq(d, p, 1'b1, c, a, b, s);
        @(negedge clk);
        while (!getRdy(d, p) && n < 60) begin
            @(negedge clk);
            n++;
        end
        chk($sformatf("req_accept_dut%0d_port%0d", d, p), {31'd0, getRdy(d, p)}, 32'd1);
        @(posedge clk);
        #1;
        setReq(d, p, 1'b0, c, a, b, s);
    endtask

    task automatic waitDrain(input int d);
        int n;
        n = 0;
        while (((d == 0) ? qA.size() : qB.size()) > 0 && n < 100) begin
            @(negedge clk);
            n++;
        end
        chk($sformatf("drain_dut%0d", d), (d == 0) ? qA.size() : qB.size(), 32'd0);
        @(posedge clk);
        #1;
    endtask

    initial begin
        int n;
        rst = 1'b1;
        accCyc[0] = 0;
        accCyc[1] = 0;
        for (int d = 0; d < 2; d++)
            for (int p = 0; p < 2; p++) setReq(d, p, 1'b0, 4'd0, 32'd0, 32'd0, 1'b0);
        busA.rsp0_ready = 1'b1; busA.rsp1_ready = 1'b1;
        busB.rsp0_ready = 1'b1; busB.rsp1_ready = 1'b1;
        busA.req0_valid = 1'b1;
        repeat (2) @(negedge clk);
        chk("rst_req0_ready", {31'd0, busA.req0_ready}, 32'd0);
        chk("rst_rsp_valids", {30'd0, busA.rsp1_valid, busA.rsp0_valid}, 32'd0);
        chk("rst_rsp_result", busA.rsp_result, 32'd0);
        chk("rst_status_reg", {28'd0, busA.status_reg}, 32'd0);
        chk("rst_alu_ops", busA.alu_a | busA.alu_b | {28'd0, busA.alu_cmd}, 32'd0);
        chk("rst_carry_in", {31'd0, busA.alu_carry_in}, 32'd0);
        busA.req0_valid = 1'b0;
        @(posedge clk);
        #1 rst = 1'b0;

        // Round-robin contention: first tie after reset goes to port 0, then alternates.
        for (int i = 1; i <= 4; i++) begin
            pushExp(0, 1'b0, 32'd100 + i, 4'b0000, 4'b0000);
            pushExp(0, 1'b1, 32'hFFFF_FFFF - i, 4'b1000, 4'b0000);
        end
        fork
            for (int i = 1; i <= 4; i++) sendReq(0, 0, ADD, i, 32'd100, 1'b0);
            for (int i = 1; i <= 4; i++) sendReq(0, 1, MVN, 32'd0, i, 1'b0);
        join
        waitDrain(0);

        // Single op, carry chain and s=0 isolation.
        pushExp(0, 1'b0, 32'd12, 4'b0000, 4'b0000);
        sendReq(0, 0, ADD, 32'd5, 32'd7, 1'b1);
        waitDrain(0);
        pushExp(0, 1'b0, 32'd0, 4'b0110, 4'b0110);
        sendReq(0, 0, ADD, 32'hFFFF_FFFF, 32'd1, 1'b1);
        waitDrain(0);
        pushExp(0, 1'b1, 32'd0, 4'b0110, 4'b0110);
        sendReq(0, 1, SUB, 32'd3, 32'd3, 1'b0);
        waitDrain(0);
        pushExp(0, 1'b1, 32'hFFFF_FFFF, 4'b1000, 4'b0110);
        sendReq(0, 1, SUB, 32'd1, 32'd2, 1'b0);
        waitDrain(0);
        pushExp(0, 1'b0, 32'd3, 4'b0000, 4'b0000);
        sendReq(0, 0, ADC, 32'd1, 32'd1, 1'b1);
        chk("adc_carry_in", {31'd0, busA.alu_carry_in}, 32'd1);
        chk("adc_alu_cmd", {28'd0, busA.alu_cmd}, {28'd0, ADC});
        waitDrain(0);

        // Response backpressure with a competing request on port 1.
        busA.rsp0_ready = 1'b0;
        pushExp(0, 1'b0, 32'h0000_ABCD, 4'b0000, 4'b0000);
        sendReq(0, 0, MOV, 32'd0, 32'h0000_ABCD, 1'b0);
        setReq(0, 1, 1'b1, EOR, 32'hF0, 32'hFF, 1'b0);
        n = 0;
        while (!busA.rsp0_valid && n < 10) begin
            @(negedge clk);
            n++;
        end
        for (int k = 0; k < 5; k++) begin
            chk("bp_rsp0_valid", {31'd0, busA.rsp0_valid}, 32'd1);
            chk("bp_rsp_result", busA.rsp_result, 32'h0000_ABCD);
            chk("bp_req1_ready", {31'd0, busA.req1_ready}, 32'd0);
            @(negedge clk);
        end
        pushExp(0, 1'b1, 32'h0000_000F, 4'b0000, 4'b0000);
        @(posedge clk);
        #1 busA.rsp0_ready = 1'b1;
        sendReq(0, 1, EOR, 32'hF0, 32'hFF, 1'b0);
        waitDrain(0);

        // Fixed priority: port 1 only wins once port 0 stops requesting.
        pushExp(1, 1'b0, 32'h0000_FF00, 4'b0000, 4'b0000);
        pushExp(1, 1'b0, 32'hFF00_0000, 4'b1000, 4'b0000);
        pushExp(1, 1'b0, 32'h0000_0000, 4'b0100, 4'b0000);
        pushExp(1, 1'b1, 32'h0000_0055, 4'b0000, 4'b0000);
        fork
            begin
                sendReq(1, 0, AND, 32'hFF00_FF00, 32'h0000_FFFF, 1'b0);
                sendReq(1, 0, AND, 32'hFF00_FF00, 32'hFFFF_0000, 1'b0);
                sendReq(1, 0, AND, 32'h0F0F_0F0F, 32'hF0F0_F0F0, 1'b0);
            end
            sendReq(1, 1, MOV, 32'd0, 32'h55, 1'b0);
        join
        waitDrain(1);

        // Reset while a flag-setting op sits in RESP.
        busA.rsp0_ready = 1'b0;
        sendReq(0, 0, MVN, 32'd0, 32'd0, 1'b1);
        n = 0;
        while (!busA.rsp0_valid && n < 10) begin
            @(negedge clk);
            n++;
        end
        chk("pre_rst_status_reg", {28'd0, busA.status_reg}, 32'h8);
        #1 rst = 1'b1;
        #1;
        chk("mid_rst_rsp0_valid", {31'd0, busA.rsp0_valid}, 32'd0);
        chk("mid_rst_rsp_result", busA.rsp_result, 32'd0);
        chk("mid_rst_rsp_status", {28'd0, busA.rsp_status}, 32'd0);
        chk("mid_rst_status_reg", {28'd0, busA.status_reg}, 32'd0);
        chk("mid_rst_alu_b", busA.alu_b, 32'd0);
        @(posedge clk);
        #1 rst = 1'b0;
        busA.rsp0_ready = 1'b1;
        for (int k = 0; k < 5; k++) begin
            @(negedge clk);
            chk("post_rst_rsp0_valid", {31'd0, busA.rsp0_valid}, 32'd0);
            chk("post_rst_status_reg", {28'd0, busA.status_reg}, 32'd0);
        end

        $display("CHECKS %0d ERRORS %0d", checks, errors);
        $finish;
    end
endmodule
